dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Single-port data-memory arbiter and sequencer between the store FIFO head and the out-of-order load queue. It grants one request at a time onto the dmem interface and holds it stable until `dmem_resp`. Branch mispredicts squash the in-flight load without breaking the memory handshake. Returning data and store completions are forwarded as registered one-cycle pulses toward writeback and store-tag broadcast.

## Interface
Parameters:
- `ROB_DEPTH`, 32, ROB entries; `RW = $clog2(ROB_DEPTH)`
- `BMASK_W`, 4, branch-mask width; `BW = $clog2(BMASK_W)`
- `STARVE_LIMIT`, 4, consecutive store grants tolerated while a load waits (guard build only)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `st_req_valid` in 1; `st_req_ready` out 1: store handshake
- `st_req_addr` in 32; `st_req_wdata` in 32; `st_req_wmask` in 4; `st_req_rob_idx` in RW; `st_req_bmask` in BMASK_W
- `ld_req_valid` in 1; `ld_req_ready` out 1: load handshake
- `ld_req_addr` in 32; `ld_req_rmask` in 4; `ld_req_rob_idx` in RW; `ld_req_bmask` in BMASK_W
- `rob_head_idx` in RW: a store is eligible only when `st_req_rob_idx == rob_head_idx`
- `br_broadcast` in 1; `br_mispred` in 1; `br_bit` in BW: branch resolution
- `dmem_addr` out 32; `dmem_wdata` out 32; `dmem_rmask` out 4; `dmem_wmask` out 4
- `dmem_resp` in 1; `dmem_rdata` in 32
- `ld_resp_valid` out 1; `ld_resp_rdata` out 32; `ld_resp_rob_idx` out RW
- `st_done_valid` out 1; `st_done_rob_idx` out RW
- `busy` out 1: state is not IDLE

## Operation
- FSM has three states: IDLE, BUSY, SQUASH. Held registers: `addr`, `wdata`, `rmask`, `wmask`, `rob_idx`, `bmask`, `is_store`.
- A grant is possible when state is IDLE, or when state is BUSY/SQUASH and `dmem_resp=1`.
- Eligibility:
  - Store: `st_req_valid` and ROB head match.
  - Load: `ld_req_valid`.
- Priority: store over load.
- `*_req_ready` is asserted only for the granted requester; the handshake completes at that clock edge.
- Kill-on-arrival: if `br_broadcast & br_mispred & ld_req_bmask[br_bit]`, the load is consumed (`ld_req_ready=1`) but not issued, and it does not block a store grant that cycle. Stores are never killed.
- Grant effects: held registers load the request, `bmask` is loaded with this cycle's resolution applied, and the next state is BUSY.
- With no grant in a cycle that has `dmem_resp`, the next state is IDLE and all `dmem_*` outputs clear to 0.
- BUSY handling:
  - Correct resolution (`br_broadcast & ~br_mispred`) clears `bmask[br_bit]`.
  - Mispredict hitting a held load moves the next state to SQUASH, unless `dmem_resp` is the same cycle. In that case the response is dropped and no grant is taken that cycle.
- SQUASH: `dmem_*` outputs stay held until `dmem_resp`, and the response is discarded.
- `dmem_resp` in IDLE is ignored.

## Timing
- Reset value of every output is 0; state resets to IDLE; starvation counter resets to 0.
- Request latency: grant at edge N, and `dmem_*` outputs are driven from cycle N+1. They are held constant through the `dmem_resp` cycle inclusive.
- Back-to-back: a grant in the `dmem_resp` cycle drives the new request starting the next cycle, with no idle gap.
- Response latency: `dmem_resp` at cycle M produces a one-cycle pulse of `ld_resp_valid` (with registered `rdata`) or `st_done_valid` in cycle M+1.
- No response pulse is produced from SQUASH.
- `rst` mid-transaction drops the transaction immediately. The memory is expected to be reset by the same `rst`.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - A counter of width `$clog2(STARVE_LIMIT)+1` increments on each store grant made while `ld_req_valid=1`.
  - It resets on any load grant, or when a store grant is made with no load waiting.
  - When the counter reaches `STARVE_LIMIT`, the next grant favours the load over an eligible store.
- `DMEM_ARB_STARVE_GUARD_EN` undefined: strict store priority, and no counter is instantiated.

## Test plan
- Single load: addr 0x100, rmask 0xF, rob 5, `dmem_resp` 3 cycles after the outputs appear, rdata 0xDEADBEEF.
  - Required: `dmem_rmask` is 0xF for 4 cycles, then 0.
  - Required: `ld_resp_valid`, 0xDEADBEEF, rob 5 appear one cycle after `dmem_resp`.
- Store and load valid together, `rob_head_idx` equal to the store's rob 7.
  - Required: the store is granted first (`dmem_wmask` nonzero), then the load is granted in the store's resp cycle with no idle gap.
  - Required: `st_done_rob_idx=7`.
- Store valid but `rob_head_idx` is 2 while the store's rob is 9; load also valid.
  - Required: the load is granted and `st_req_ready` stays 0.
- Load with bmask 0b0010 in flight; mispredict with `br_bit=1` two cycles before `dmem_resp`.
  - Required: state goes to SQUASH, masks are held until resp, no `ld_resp_valid`, then IDLE.
- Load with bmask 0b0100 while the same cycle has a correct resolution of bit 2 followed by a mispredict of bit 2.
  - Required: the load completes normally with `ld_resp_valid`.
- With the guard defined and `STARVE_LIMIT=4`: continuous eligible stores plus a waiting load.
  - Required: the load is granted as the 5th grant.
  - Without the macro, the load is never granted while stores remain eligible.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: request, memory-side and completion signals of the
// data-memory port arbiter. slave = arbiter side, master = environment side.
interface dmem_port_arbiter_if #(
   parameter int unsigned ROB_DEPTH = 32,
   parameter int unsigned BMASK_W   = 4
);
   localparam int unsigned RW = $clog2(ROB_DEPTH);
   localparam int unsigned BW = $clog2(BMASK_W);

   // store FIFO head
   logic               st_req_valid;
   logic               st_req_ready;
   logic [31:0]        st_req_addr;
   logic [31:0]        st_req_wdata;
   logic [3:0]         st_req_wmask;
   logic [RW-1:0]      st_req_rob_idx;
   logic [BMASK_W-1:0] st_req_bmask;

   // load queue
   logic               ld_req_valid;
   logic               ld_req_ready;
   logic [31:0]        ld_req_addr;
   logic [3:0]         ld_req_rmask;
   logic [RW-1:0]      ld_req_rob_idx;
   logic [BMASK_W-1:0] ld_req_bmask;

   // ROB head and branch resolution
   logic [RW-1:0]      rob_head_idx;
   logic               br_broadcast;
   logic               br_mispred;
   logic [BW-1:0]      br_bit;

   // data memory
   logic [31:0]        dmem_addr;
   logic [31:0]        dmem_wdata;
   logic [3:0]         dmem_rmask;
   logic [3:0]         dmem_wmask;
   logic               dmem_resp;
   logic [31:0]        dmem_rdata;

   // completions
   logic               ld_resp_valid;
   logic [31:0]        ld_resp_rdata;
   logic [RW-1:0]      ld_resp_rob_idx;
   logic               st_done_valid;
   logic [RW-1:0]      st_done_rob_idx;
   logic               busy;

   modport slave (
      input  st_req_valid, st_req_addr, st_req_wdata, st_req_wmask,
             st_req_rob_idx, st_req_bmask,
      input  ld_req_valid, ld_req_addr, ld_req_rmask, ld_req_rob_idx,
             ld_req_bmask,
      input  rob_head_idx, br_broadcast, br_mispred, br_bit,
      input  dmem_resp, dmem_rdata,
      output st_req_ready, ld_req_ready,
      output dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask,
      output ld_resp_valid, ld_resp_rdata, ld_resp_rob_idx,
      output st_done_valid, st_done_rob_idx, busy
   );

   modport master (
      output st_req_valid, st_req_addr, st_req_wdata, st_req_wmask,
             st_req_rob_idx, st_req_bmask,
      output ld_req_valid, ld_req_addr, ld_req_rmask, ld_req_rob_idx,
             ld_req_bmask,
      output rob_head_idx, br_broadcast, br_mispred, br_bit,
      output dmem_resp, dmem_rdata,
      input  st_req_ready, ld_req_ready,
      input  dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask,
      input  ld_resp_valid, ld_resp_rdata, ld_resp_rob_idx,
      input  st_done_valid, st_done_rob_idx, busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: single-port data-memory arbiter between the store FIFO
// head and the out-of-order load queue. One request at a time is held on
// dmem_* until dmem_resp; a mispredict squashes an in-flight load without
// breaking the memory handshake. Completions are registered 1-cycle pulses.
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN -- after STARVE_LIMIT
// consecutive store grants that bypassed a waiting load, the load wins.
module dmem_port_arbiter #(
   parameter int unsigned ROB_DEPTH    = 32,
   parameter int unsigned BMASK_W      = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                rst,
   dmem_port_arbiter_if.slave bus
);
   localparam int unsigned RW = $clog2(ROB_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      SQUASH = 2'd2
   } state_e;

   if (STARVE_LIMIT == 0) begin : g_limit_chk
      $error("STARVE_LIMIT must be at least 1");
   end

   state_e             state_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         rmask_q;
   logic [3:0]         wmask_q;
   logic [RW-1:0]      rob_idx_q;
   logic [BMASK_W-1:0] bmask_q;
   logic               is_store_q;

   logic               ld_resp_valid_q;
   logic [31:0]        ld_resp_rdata_q;
   logic [RW-1:0]      ld_resp_rob_idx_q;
   logic               st_done_valid_q;
   logic [RW-1:0]      st_done_rob_idx_q;

   logic               st_elig;
   logic               ld_kill;
   logic               ld_elig;
   logic               held_hit;
   logic               slot;
   logic               grant_st;
   logic               grant_ld;
   logic               kill_ld;
   logic               resp_ok;
   logic               favour_ld;
   logic [BMASK_W-1:0] res_clr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(STARVE_LIMIT) + 1;
   logic [CW-1:0] starve_q;

   // Count store grants that bypassed a waiting load; saturate at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else if (grant_st) begin
         if (!bus.ld_req_valid)
            starve_q <= '0;
         else if (starve_q < CW'(STARVE_LIMIT))
            starve_q <= starve_q + 1'b1;
      end else if (grant_ld) begin
         starve_q <= '0;
      end
   end

   // Once the limit is reached the next grant goes to an eligible load.
   always_comb favour_ld = (starve_q >= CW'(STARVE_LIMIT));
`else
   // Strict store priority.
   always_comb favour_ld = 1'b0;
`endif

   // Eligibility, squash detection and grant selection for this cycle.
   always_comb begin
      res_clr = '0;
      if (bus.br_broadcast && !bus.br_mispred)
         res_clr[bus.br_bit] = 1'b1;
      st_elig  = bus.st_req_valid && (bus.st_req_rob_idx == bus.rob_head_idx);
      ld_kill  = bus.br_broadcast && bus.br_mispred && bus.ld_req_bmask[bus.br_bit];
      ld_elig  = bus.ld_req_valid && !ld_kill;
      held_hit = (state_q == BUSY) && !is_store_q && bus.br_broadcast &&
                 bus.br_mispred && bmask_q[bus.br_bit];
      // A response that coincides with squashing the held load is dropped
      // and does not open a grant slot.
      slot     = (state_q == IDLE) || (bus.dmem_resp && !held_hit);
      resp_ok  = (state_q == BUSY) && bus.dmem_resp && !held_hit;
      grant_st = slot && st_elig && !(favour_ld && ld_elig);
      grant_ld = slot && ld_elig && !grant_st;
      kill_ld  = slot && bus.ld_req_valid && ld_kill;
   end

   // Sequencer: grant, hold, squash, and completion pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         addr_q            <= '0;
         wdata_q           <= '0;
         rmask_q           <= '0;
         wmask_q           <= '0;
         rob_idx_q         <= '0;
         bmask_q           <= '0;
         is_store_q        <= 1'b0;
         ld_resp_valid_q   <= 1'b0;
         ld_resp_rdata_q   <= '0;
         ld_resp_rob_idx_q <= '0;
         st_done_valid_q   <= 1'b0;
         st_done_rob_idx_q <= '0;
      end else begin
         ld_resp_valid_q <= 1'b0;
         st_done_valid_q <= 1'b0;
         if (resp_ok) begin
            if (is_store_q) begin
               st_done_valid_q   <= 1'b1;
               st_done_rob_idx_q <= rob_idx_q;
            end else begin
               ld_resp_valid_q   <= 1'b1;
               ld_resp_rdata_q   <= bus.dmem_rdata;
               ld_resp_rob_idx_q <= rob_idx_q;
            end
         end

         if (grant_st) begin
            state_q    <= BUSY;
            addr_q     <= bus.st_req_addr;
            wdata_q    <= bus.st_req_wdata;
            rmask_q    <= '0;
            wmask_q    <= bus.st_req_wmask;
            rob_idx_q  <= bus.st_req_rob_idx;
            bmask_q    <= bus.st_req_bmask & ~res_clr;
            is_store_q <= 1'b1;
         end else if (grant_ld) begin
            state_q    <= BUSY;
            addr_q     <= bus.ld_req_addr;
            wdata_q    <= '0;
            rmask_q    <= bus.ld_req_rmask;
            wmask_q    <= '0;
            rob_idx_q  <= bus.ld_req_rob_idx;
            bmask_q    <= bus.ld_req_bmask & ~res_clr;
            is_store_q <= 1'b0;
         end else if ((state_q != IDLE) && bus.dmem_resp) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rmask_q    <= '0;
            wmask_q    <= '0;
            rob_idx_q  <= '0;
            bmask_q    <= '0;
            is_store_q <= 1'b0;
         end else if (state_q == BUSY) begin
            bmask_q <= bmask_q & ~res_clr;
            if (held_hit)
               state_q <= SQUASH;
         end
      end
   end

   assign bus.st_req_ready    = grant_st;
   assign bus.ld_req_ready    = grant_ld || kill_ld;
   assign bus.dmem_addr       = addr_q;
   assign bus.dmem_wdata      = wdata_q;
   assign bus.dmem_rmask      = rmask_q;
   assign bus.dmem_wmask      = wmask_q;
   assign bus.ld_resp_valid   = ld_resp_valid_q;
   assign bus.ld_resp_rdata   = ld_resp_rdata_q;
   assign bus.ld_resp_rob_idx = ld_resp_rob_idx_q;
   assign bus.st_done_valid   = st_done_valid_q;
   assign bus.st_done_rob_idx = st_done_rob_idx_q;
   assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus a randomized run, checked
// against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
   localparam int unsigned ROB_DEPTH    = 32;
   localparam int unsigned BMASK_W      = 4;
   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned RW = $clog2(ROB_DEPTH);
   localparam int unsigned BW = $clog2(BMASK_W);
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ROB_DEPTH(ROB_DEPTH), .BMASK_W(BMASK_W)) bus ();

   dmem_port_arbiter #(
      .ROB_DEPTH(ROB_DEPTH),
      .BMASK_W(BMASK_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic [31:0]        addr;
      logic [31:0]        wdata;
      logic [3:0]         rmask;
      logic [3:0]         wmask;
      logic [RW-1:0]      rob;
      logic [BMASK_W-1:0] bmask;
      logic               st;
   } txn_t;

   txn_t               cur;      // transaction owning the memory port
   bit                 have;     // port is owned
   bit                 dead;     // owner was squashed, response will be discarded
   int unsigned        starve;   // store grants that bypassed a waiting load
   bit                 e_ldv, e_stv;
   logic [31:0]        e_ldd;
   logic [RW-1:0]      e_ldr, e_str;
   bit                 m_gst, m_gld, m_kill, m_hit;
   logic [BMASK_W-1:0] m_clr;
   logic               last_ld_ready;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      cur = '0; have = 0; dead = 0; starve = 0;
      e_ldv = 0; e_stv = 0; e_ldd = '0; e_ldr = '0; e_str = '0;
   endtask

   // Decide what this cycle's inputs entitle each requester to.
   task automatic model_comb();
      bit st_ok, ld_doa, ld_ok, open, favour;
      m_clr = '0;
      if (bus.br_broadcast && !bus.br_mispred) m_clr[bus.br_bit] = 1'b1;
      st_ok  = bus.st_req_valid && (bus.st_req_rob_idx == bus.rob_head_idx);
      ld_doa = bus.br_broadcast && bus.br_mispred && bus.ld_req_bmask[bus.br_bit];
      ld_ok  = bus.ld_req_valid && !ld_doa;
      m_hit  = have && !dead && !cur.st && bus.br_broadcast && bus.br_mispred &&
               cur.bmask[bus.br_bit];
      open   = !have || (bus.dmem_resp && !m_hit);
      favour = GUARD && (starve >= STARVE_LIMIT);
      m_gst  = open && st_ok && !(favour && ld_ok);
      m_gld  = open && ld_ok && !m_gst;
      m_kill = open && bus.ld_req_valid && ld_doa;
   endtask

   // Advance the model at the clock edge.
   task automatic model_seq();
      e_ldv = 0; e_stv = 0;
      if (have && !dead && bus.dmem_resp && !m_hit) begin
         if (cur.st) begin e_stv = 1; e_str = cur.rob; end
         else begin e_ldv = 1; e_ldd = bus.dmem_rdata; e_ldr = cur.rob; end
      end
      if (m_gst) begin
         cur.addr = bus.st_req_addr; cur.wdata = bus.st_req_wdata;
         cur.rmask = '0; cur.wmask = bus.st_req_wmask;
         cur.rob = bus.st_req_rob_idx; cur.bmask = bus.st_req_bmask & ~m_clr;
         cur.st = 1'b1; have = 1; dead = 0;
         starve = bus.ld_req_valid ? starve + 1 : 0;
      end else if (m_gld) begin
         cur.addr = bus.ld_req_addr; cur.wdata = '0;
         cur.rmask = bus.ld_req_rmask; cur.wmask = '0;
         cur.rob = bus.ld_req_rob_idx; cur.bmask = bus.ld_req_bmask & ~m_clr;
         cur.st = 1'b0; have = 1; dead = 0;
         starve = 0;
      end else if (have && bus.dmem_resp) begin
         have = 0;
      end else if (have && !dead) begin
         cur.bmask = cur.bmask & ~m_clr;
         if (m_hit) dead = 1;
      end
   endtask

   task automatic check_outputs();
      txn_t v;
      v = have ? cur : '0;
      check_eq("dmem_addr",  bus.dmem_addr,  v.addr);
      check_eq("dmem_wdata", bus.dmem_wdata, v.wdata);
      check_eq("dmem_rmask", bus.dmem_rmask, v.rmask);
      check_eq("dmem_wmask", bus.dmem_wmask, v.wmask);
      check_eq("busy",       bus.busy,       have);
      check_eq("ld_resp_valid", bus.ld_resp_valid, e_ldv);
      if (e_ldv) begin
         check_eq("ld_resp_rdata",   bus.ld_resp_rdata,   e_ldd);
         check_eq("ld_resp_rob_idx", bus.ld_resp_rob_idx, e_ldr);
      end
      check_eq("st_done_valid", bus.st_done_valid, e_stv);
      if (e_stv) check_eq("st_done_rob_idx", bus.st_done_rob_idx, e_str);
   endtask

   // Called at posedge+1 with inputs applied: check readies, clock, check outputs.
   task automatic cycle();
      #2;
      model_comb();
      last_ld_ready = bus.ld_req_ready;
      check_eq("st_req_ready", bus.st_req_ready, m_gst);
      check_eq("ld_req_ready", bus.ld_req_ready, m_gld || m_kill);
      @(posedge clk);
      model_seq();
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.st_req_valid = 0; bus.st_req_addr = '0; bus.st_req_wdata = '0;
      bus.st_req_wmask = '0; bus.st_req_rob_idx = '0; bus.st_req_bmask = '0;
      bus.ld_req_valid = 0; bus.ld_req_addr = '0; bus.ld_req_rmask = '0;
      bus.ld_req_rob_idx = '0; bus.ld_req_bmask = '0;
      bus.rob_head_idx = '0; bus.br_broadcast = 0; bus.br_mispred = 0;
      bus.br_bit = '0; bus.dmem_resp = 0; bus.dmem_rdata = '0;
   endtask

   task automatic set_load(input logic [31:0] a, input logic [RW-1:0] r, input logic [BMASK_W-1:0] bm);
      bus.ld_req_valid = 1; bus.ld_req_addr = a; bus.ld_req_rmask = 4'hF;
      bus.ld_req_rob_idx = r; bus.ld_req_bmask = bm;
   endtask

   initial begin
      int unsigned cnt;
      int unsigned first_ld;
      rst = 1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 0;

      // single load, response 3 cycles after outputs appear
      set_load(32'h100, RW'(5), '0);
      cycle();
      bus.ld_req_valid = 0;
      bus.dmem_rdata = 32'hDEADBEEF;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.dmem_rmask == 4'hF) cnt++;
         bus.dmem_resp = (i == 3);
         cycle();
      end
      bus.dmem_resp = 0;
      check_eq("t1_rmask_cycles", cnt, 4);
      check_eq("t1_rmask_clear", bus.dmem_rmask, 4'h0);
      check_eq("t1_ld_resp", bus.ld_resp_valid, 1'b1);
      check_eq("t1_rdata", bus.ld_resp_rdata, 32'hDEADBEEF);
      check_eq("t1_rob", bus.ld_resp_rob_idx, 5);
      cycle();

      // store and load together, store at ROB head
      bus.rob_head_idx = RW'(7);
      bus.st_req_valid = 1; bus.st_req_addr = 32'h200; bus.st_req_wdata = 32'h12345678;
      bus.st_req_wmask = 4'h3; bus.st_req_rob_idx = RW'(7); bus.st_req_bmask = '0;
      set_load(32'h300, RW'(8), '0);
      cycle();
      check_eq("t2_store_first", bus.dmem_wmask, 4'h3);
      bus.st_req_valid = 0;
      cycle();
      bus.dmem_resp = 1;
      #2;
      check_eq("t2_ld_grant_in_resp", bus.ld_req_ready, 1'b1);
      cycle();
      bus.dmem_resp = 0; bus.ld_req_valid = 0;
      check_eq("t2_st_done", bus.st_done_valid, 1'b1);
      check_eq("t2_st_rob", bus.st_done_rob_idx, 7);
      check_eq("t2_no_gap", bus.dmem_rmask, 4'hF);
      cycle();
      bus.dmem_resp = 1; cycle(); bus.dmem_resp = 0; cycle();

      // store not at ROB head never wins
      bus.rob_head_idx = RW'(2);
      bus.st_req_valid = 1; bus.st_req_rob_idx = RW'(9); bus.st_req_wmask = 4'hF;
      set_load(32'h500, RW'(4), '0);
      #2;
      check_eq("t3_st_blocked", bus.st_req_ready, 1'b0);
      check_eq("t3_ld_granted", bus.ld_req_ready, 1'b1);
      cycle();
      bus.ld_req_valid = 0;
      cycle();
      bus.dmem_resp = 1; cycle(); bus.dmem_resp = 0; bus.st_req_valid = 0;
      cycle();

      // squash of an in-flight load
      set_load(32'h600, RW'(6), 4'b0010);
      cycle();
      bus.ld_req_valid = 0;
      cycle();
      bus.br_broadcast = 1; bus.br_mispred = 1; bus.br_bit = BW'(1);
      cycle();
      bus.br_broadcast = 0; bus.br_mispred = 0;
      check_eq("t4_squash_busy", bus.busy, 1'b1);
      check_eq("t4_rmask_held", bus.dmem_rmask, 4'hF);
      cycle();
      bus.dmem_resp = 1; bus.dmem_rdata = 32'hBAD0BAD0;
      cycle();
      bus.dmem_resp = 0;
      check_eq("t4_no_ld_resp", bus.ld_resp_valid, 1'b0);
      check_eq("t4_idle", bus.busy, 1'b0);
      cycle();

      // correct resolution at grant clears the bit; later mispredict misses
      set_load(32'h700, RW'(11), 4'b0100);
      bus.br_broadcast = 1; bus.br_mispred = 0; bus.br_bit = BW'(2);
      cycle();
      bus.ld_req_valid = 0; bus.br_mispred = 1;
      cycle();
      bus.br_broadcast = 0; bus.br_mispred = 0;
      bus.dmem_resp = 1; bus.dmem_rdata = 32'hA5A50001;
      cycle();
      bus.dmem_resp = 0;
      check_eq("t5_ld_resp", bus.ld_resp_valid, 1'b1);
      check_eq("t5_rob", bus.ld_resp_rob_idx, 11);
      cycle();

      // continuous eligible stores plus a waiting load
      bus.rob_head_idx = RW'(3);
      bus.st_req_valid = 1; bus.st_req_rob_idx = RW'(3); bus.st_req_wmask = 4'hF;
      bus.st_req_addr = 32'h800;
      set_load(32'h900, RW'(12), '0);
      first_ld = 0;
      for (int g = 1; g <= 8; g++) begin
         bus.dmem_resp = (g > 1);
         cycle();
         if (last_ld_ready && first_ld == 0) first_ld = g;
         if (last_ld_ready) bus.ld_req_valid = 0;
      end
      check_eq("t6_load_grant_no", first_ld, GUARD ? 5 : 0);
      bus.st_req_valid = 0; bus.ld_req_valid = 0;
      bus.dmem_resp = 1; cycle();
      bus.dmem_resp = 0; cycle();

      // randomized run with one reset in the middle of traffic
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            rst = 1;
            #1;
            model_reset();
            check_outputs();
            @(posedge clk);
            #1;
            rst = 0;
         end
         bus.rob_head_idx   = RW'($urandom_range(0, ROB_DEPTH - 1));
         bus.st_req_valid   = 1'($urandom_range(0, 2) != 0);
         bus.st_req_rob_idx = ($urandom_range(0, 3) != 0) ? bus.rob_head_idx
                                                          : RW'($urandom_range(0, ROB_DEPTH - 1));
         bus.st_req_addr    = $urandom;
         bus.st_req_wdata   = $urandom;
         bus.st_req_wmask   = 4'($urandom_range(1, 15));
         bus.st_req_bmask   = BMASK_W'($urandom & $urandom);
         bus.ld_req_valid   = 1'($urandom_range(0, 1));
         bus.ld_req_addr    = $urandom;
         bus.ld_req_rmask   = 4'($urandom_range(1, 15));
         bus.ld_req_rob_idx = RW'($urandom_range(0, ROB_DEPTH - 1));
         bus.ld_req_bmask   = BMASK_W'($urandom & $urandom);
         bus.br_broadcast   = 1'($urandom_range(0, 3) == 0);
         bus.br_mispred     = 1'($urandom_range(0, 1));
         bus.br_bit         = BW'($urandom_range(0, BMASK_W - 1));
         bus.dmem_resp      = have ? 1'($urandom_range(0, 2) == 0)
                                   : 1'($urandom_range(0, 7) == 0);
         bus.dmem_rdata     = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
